io_input_cond: RTL and testbench

IO_INPUT_COND -- requirements
Module: io_input_cond

---
 rtl/io_input_cond.sv | 88 ++++++++
 tb/tb_io_input_cond.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_cond.sv
// rtl/io_input_cond.sv - synchronizes and debounces board switches/keys, with sticky key-press flags.
// Optional key_evt logic is built only when IO_INPUT_COND_KEY_EVT_EN is defined.
module io_input_cond #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [9:0] sw_raw,
  input  logic [2:0] key_raw,
  input  logic       key_rd,
  output logic [9:0] sw,
  output logic [2:0] key,
  output logic [2:0] key_evt
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int NB = 13;
  // Keys are active-low, so their synchronizers and debounced levels rest at "released".
  localparam logic [NB-1:0] RST_VAL  = {3'b111, 10'b0};
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [NB-1:0] s1_q, s1_d;
  logic [NB-1:0] s2_q, s2_d;
  logic [NB-1:0] db_q, db_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];

  always_comb begin
    s1_d = {key_raw, sw_raw};
    s2_d = s1_q;
    db_d = db_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      // Any cycle where s2 agrees with the debounced level restarts the count.
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      db_q <= RST_VAL;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      db_q <= db_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw  = db_q[9:0];
  assign key = db_q[12:10];

`ifdef IO_INPUT_COND_KEY_EVT_EN
  logic [2:0] evt_q, evt_d;

  // A press (debounced 1->0) beats a simultaneous read-clear.
  always_comb begin
    evt_d = (key_rd ? 3'b000 : evt_q) | (db_q[12:10] & ~db_d[12:10]);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      evt_q <= 3'b000;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign key_evt = evt_q;
`else
  logic unused_key_rd;
  assign unused_key_rd = key_rd;
  assign key_evt       = 3'b000;
`endif

endmodule

// File: tb/tb_io_input_cond.sv
// tb/tb_io_input_cond.sv - scoreboard bench for io_input_cond (DB_CYCLES=16 and DB_CYCLES=1 instances).
module tb_io_input_cond;
`ifdef IO_INPUT_COND_KEY_EVT_EN
    localparam bit EVT_EN = 1'b1;
`else
    localparam bit EVT_EN = 1'b0;
`endif

    logic       clock;
    logic       resetn;
    logic [9:0] sw_raw, sw_raw1;
    logic [2:0] key_raw, key_raw1;
    logic       key_rd, key_rd1;
    logic [9:0] sw, sw1;
    logic [2:0] key, key1;
    logic [2:0] key_evt, key_evt1;

    io_input_cond #(.DB_CYCLES(16)) dut (
        .clock(clock), .resetn(resetn), .sw_raw(sw_raw), .key_raw(key_raw),
        .key_rd(key_rd), .sw(sw), .key(key), .key_evt(key_evt)
    );

    io_input_cond #(.DB_CYCLES(1)) dut1 (
        .clock(clock), .resetn(resetn), .sw_raw(sw_raw1), .key_raw(key_raw1),
        .key_rd(key_rd1), .sw(sw1), .key(key1), .key_evt(key_evt1)
    );

    typedef struct {
        int         cyc;
        bit         which;
        logic [9:0] sw;
        logic [2:0] key;
        logic [2:0] evt;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    function automatic logic [2:0] ev(input logic [2:0] x);
        return EVT_EN ? x : 3'b000;
    endfunction

    function automatic void chk(input int at, input string nm, input bit which,
                                input logic [9:0] s, input logic [2:0] k, input logic [2:0] e);
        exp_t x;
        x.cyc   = at;
        x.which = which;
        x.sw    = s;
        x.key   = k;
        x.evt   = e;
        x.name  = nm;
        q.push_back(x);
    endfunction

    task automatic goto(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    logic [9:0] m_sw;
    logic [2:0] m_key, m_evt;

    always @(negedge clock) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                m_sw  = q[i].which ? sw1 : sw;
                m_key = q[i].which ? key1 : key;
                m_evt = q[i].which ? key_evt1 : key_evt;
                total = total + 1;
                if (m_sw !== q[i].sw || m_key !== q[i].key || m_evt !== q[i].evt) begin
                    bad = bad + 1;
                    $display("FAIL %s @%0d: got sw=%h key=%b evt=%b, want sw=%h key=%b evt=%b",
                             q[i].name, cyc, m_sw, m_key, m_evt, q[i].sw, q[i].key, q[i].evt);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        resetn   = 1'b0;
        sw_raw   = 10'h000;
        key_raw  = 3'b111;
        key_rd   = 1'b0;
        sw_raw1  = 10'h000;
        key_raw1 = 3'b111;
        key_rd1  = 1'b0;
        chk(2, "reset", 0, 10'h000, 3'b111, 3'b000);
        chk(2, "reset1", 1, 10'h000, 3'b111, 3'b000);

        goto(3);
        resetn  = 1'b1;
        sw_raw  = 10'h2A5;
        sw_raw1 = 10'h200;
        chk(20, "sw_hold", 0, 10'h000, 3'b111, 3'b000);
        chk(21, "sw_latency", 0, 10'h2A5, 3'b111, 3'b000);
        chk(5, "db1_hold", 1, 10'h000, 3'b111, 3'b000);
        chk(6, "db1_latency", 1, 10'h200, 3'b111, 3'b000);

        goto(10);
        key_raw1 = 3'b110;
        chk(12, "db1_key_hold", 1, 10'h200, 3'b111, 3'b000);
        chk(13, "db1_key_press", 1, 10'h200, 3'b110, ev(3'b001));

        goto(20);
        key_raw1 = 3'b111;
        chk(22, "db1_key_held", 1, 10'h200, 3'b110, ev(3'b001));
        chk(23, "db1_key_release", 1, 10'h200, 3'b111, ev(3'b001));

        goto(25);
        key_raw = 3'b110;

        goto(30);
        sw_raw1 = 10'h000;
        chk(32, "db1_sw_hold", 1, 10'h200, 3'b111, ev(3'b001));
        chk(33, "db1_sw_clear", 1, 10'h000, 3'b111, ev(3'b001));

        goto(35);
        key_raw = 3'b111;
        chk(37, "glitch_a", 0, 10'h2A5, 3'b111, 3'b000);
        chk(47, "glitch_b", 0, 10'h2A5, 3'b111, 3'b000);
        chk(57, "glitch_c", 0, 10'h2A5, 3'b111, 3'b000);

        goto(60);
        key_raw = 3'b110;
        chk(77, "full_restart_hold", 0, 10'h2A5, 3'b111, 3'b000);
        chk(78, "press_key1", 0, 10'h2A5, 3'b110, ev(3'b001));

        goto(80);
        key_raw = 3'b111;
        chk(97, "key1_held", 0, 10'h2A5, 3'b110, ev(3'b001));
        chk(98, "release_no_evt", 0, 10'h2A5, 3'b111, ev(3'b001));

        goto(99);
        key_rd = 1'b1;
        goto(100);
        key_rd  = 1'b0;
        key_raw = 3'b101;
        chk(100, "rd_clear", 0, 10'h2A5, 3'b111, 3'b000);
        chk(117, "press2_hold", 0, 10'h2A5, 3'b111, 3'b000);
        chk(118, "press_key2", 0, 10'h2A5, 3'b101, ev(3'b010));

        goto(125);
        key_rd = 1'b1;
        chk(126, "rd_clear_held", 0, 10'h2A5, 3'b101, 3'b000);
        chk(135, "no_reset_held", 0, 10'h2A5, 3'b101, 3'b000);
        goto(126);
        key_rd = 1'b0;

        goto(140);
        key_raw = 3'b111;
        chk(158, "release_key2", 0, 10'h2A5, 3'b111, 3'b000);

        goto(160);
        key_raw = 3'b110;
        chk(178, "press_key1_b", 0, 10'h2A5, 3'b110, ev(3'b001));

        goto(180);
        key_raw = 3'b111;
        chk(198, "release_key1_b", 0, 10'h2A5, 3'b111, ev(3'b001));

        goto(200);
        key_raw = 3'b011;
        chk(217, "pre_coincide", 0, 10'h2A5, 3'b111, ev(3'b001));
        chk(218, "press_and_rd", 0, 10'h2A5, 3'b011, ev(3'b100));
        chk(219, "press_and_rd_hold", 0, 10'h2A5, 3'b011, ev(3'b100));

        goto(217);
        key_rd = 1'b1;
        goto(218);
        key_rd = 1'b0;

        goto(220);
        key_raw = 3'b111;
        chk(238, "release_key3", 0, 10'h2A5, 3'b111, ev(3'b100));

        goto(240);
        sw_raw = 10'h000;
        chk(258, "sw_to_zero", 0, 10'h000, 3'b111, ev(3'b100));

        goto(260);
        sw_raw = 10'h001;

        goto(274);
        resetn = 1'b0;
        chk(275, "mid_count_reset", 0, 10'h000, 3'b111, 3'b000);

        goto(276);
        resetn = 1'b1;
        chk(286, "partial_discarded", 0, 10'h000, 3'b111, 3'b000);
        chk(293, "restart_hold", 0, 10'h000, 3'b111, 3'b000);
        chk(294, "restart_done", 0, 10'h001, 3'b111, 3'b000);

        goto(300);
        resetn  = 1'b0;
        key_raw = 3'b101;
        chk(302, "reset_key_held", 0, 10'h000, 3'b111, 3'b000);

        goto(305);
        resetn = 1'b1;
        chk(322, "held_thru_reset_hold", 0, 10'h000, 3'b111, 3'b000);
        chk(323, "held_thru_reset_evt", 0, 10'h001, 3'b101, ev(3'b010));
        chk(340, "held_thru_reset_once", 0, 10'h001, 3'b101, ev(3'b010));

        goto(345);
        foreach (q[i]) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", q[i].name, q[i].cyc, cyc);
        end
        total = total + 1;
        if (sw !== 10'h001 || key !== 3'b101 || key_evt !== ev(3'b010)) begin
            bad = bad + 1;
            $display("FAIL final_state: got sw=%h key=%b evt=%b", sw, key, key_evt);
        end
        if (total < 12) begin
            bad = bad + 1;
            $display("FAIL too_few_checks: total=%0d", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        if (bad == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end
endmodule
